// File: rtl/updown_counter_pkg.sv
// Shared constants and types for the TinyTapeout up/down counter.
// Includes the ui_in bit positions and the per-edge action encoding.
package updown_counter_pkg;

    localparam int WIDTH = 8;
    localparam logic [WIDTH-1:0] RESET_VAL = 8'h00;
    localparam logic [WIDTH-1:0] MIN_VAL   = '0;
    localparam logic [WIDTH-1:0] MAX_VAL   = '1;

    // Bit positions of the control fields inside ui_in.
    localparam int CNT_EN = 0;
    localparam int UP     = 1;
    localparam int LOAD   = 2;
    localparam int SAT    = 3;
    localparam int CLR    = 4;

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_CLR,
        ACT_LOAD,
        ACT_UP,
        ACT_DOWN
    } action_e;

endpackage

// File: rtl/updown_counter_core.sv
// Counter register with clear/load/count priority and wrap/saturate next-state.
// The output is the register itself, so no input reaches count combinationally.
module updown_counter_core
    import updown_counter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             clr,
    input  logic             load,
    input  logic             cnt_en,
    input  logic             up,
    input  logic             sat,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count
);

    action_e          action;
    logic [WIDTH-1:0] count_next;

    // First match wins: a disabled design ignores clear and load as well.
    always_comb begin
        // NOTE: default assigned first so every path drives action; no latch is inferred.
        action = ACT_HOLD;
        if (!ena)
            action = ACT_HOLD;
        else if (clr)
            action = ACT_CLR;
        else if (load)
            action = ACT_LOAD;
        else if (cnt_en)
            action = up ? ACT_UP : ACT_DOWN;
    end

    always_comb begin
        count_next = count;
        case (action)
            ACT_CLR:  count_next = '0;
            ACT_LOAD: count_next = load_val;
            ACT_UP: begin
                if (!(sat && count == MAX_VAL))
                    count_next = count + WIDTH'(1);
            end
            ACT_DOWN: begin
                if (!(sat && count == MIN_VAL))
                    count_next = count - WIDTH'(1);
            end
            default:  count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n)
            count <= RESET_VAL;
        else
            count <= count_next;
    end

endmodule

// File: rtl/tt_um_up_down_counter.sv
// TinyTapeout wrapper: unpacks ui_in controls, ties the bidirectionals to inputs,
// and drives uo_out straight from the counter register.
module tt_um_up_down_counter
    import updown_counter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [WIDTH-1:0] count;
    logic             unused_reserved;

    updown_counter_core u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .clr      (ui_in[CLR]),
        .load     (ui_in[LOAD]),
        .cnt_en   (ui_in[CNT_EN]),
        .up       (ui_in[UP]),
        .sat      (ui_in[SAT]),
        .load_val (uio_in),
        .count    (count)
    );

    assign uo_out  = count;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    // Reserved control bits are deliberately ignored.
    assign unused_reserved = &{1'b0, ui_in[7:5]};

endmodule

// File: tb/tb_tt_um_up_down_counter.sv
// Scoreboard bench for tt_um_up_down_counter: each driven edge queues the
// expected count, and a monitor compares it just after the rising edge.
module tb_tt_um_up_down_counter;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    tt_um_up_down_counter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor: pops one expectation per rising edge once the register has settled.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, {8'h00, uo_out}, {8'h00, e.val});
            check({e.tag, "_uio"}, {uio_oe, uio_out}, 16'h0000);
        end
    end

    // Drive inputs for one edge (called on a falling edge) and queue the expected count.
    task automatic drive(input logic en, input logic [7:0] ui, input logic [7:0] uio,
                         input logic [7:0] exp, input string tag);
        exp_t e;
        ena    = en;
        ui_in  = ui;
        uio_in = uio;
        e.tag  = tag;
        e.val  = exp;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h03;
        uio_in = 8'h00;
        #2;
        check("async_reset_initial", {8'h00, uo_out}, 16'h0000);
        @(negedge clk);

        // Reset held with counting requested: count must stay at zero.
        for (int i = 0; i < 5; i++) drive(1'b1, 8'h03, 8'h00, 8'h00, "rst_hold");
        rst_n = 1'b1;
        drive(1'b1, 8'h03, 8'h00, 8'h01, "post_rst_1");
        drive(1'b1, 8'h03, 8'h00, 8'h02, "post_rst_2");
        drive(1'b1, 8'h03, 8'h00, 8'h03, "post_rst_3");

        // Up wrap through 0xFF.
        drive(1'b1, 8'h04, 8'hFE, 8'hFE, "load_fe");
        drive(1'b1, 8'h03, 8'h00, 8'hFF, "up_wrap_ff");
        drive(1'b1, 8'h03, 8'h00, 8'h00, "up_wrap_00");
        drive(1'b1, 8'h03, 8'h00, 8'h01, "up_wrap_01");

        // Down wrap vs down saturate.
        drive(1'b1, 8'h04, 8'h01, 8'h01, "load_01a");
        drive(1'b1, 8'h01, 8'h00, 8'h00, "dn_wrap_00");
        drive(1'b1, 8'h01, 8'h00, 8'hFF, "dn_wrap_ff");
        drive(1'b1, 8'h04, 8'h01, 8'h01, "load_01b");
        drive(1'b1, 8'h09, 8'h00, 8'h00, "dn_sat_00a");
        drive(1'b1, 8'h09, 8'h00, 8'h00, "dn_sat_00b");

        // Up saturate.
        drive(1'b1, 8'h04, 8'hFD, 8'hFD, "load_fd");
        drive(1'b1, 8'h0B, 8'h00, 8'hFE, "up_sat_fe");
        for (int i = 0; i < 4; i++) drive(1'b1, 8'h0B, 8'h00, 8'hFF, "up_sat_ff");

        // Priority, enable and hold.
        drive(1'b1, 8'h17, 8'h55, 8'h00, "clr_wins");
        drive(1'b1, 8'h07, 8'h55, 8'h55, "load_over_cnt");
        for (int i = 0; i < 4; i++) drive(1'b0, 8'h03, 8'hAA, 8'h55, "ena_hold");
        drive(1'b0, 8'h14, 8'hAA, 8'h55, "ena_blocks_clr");
        drive(1'b1, 8'h02, 8'hAA, 8'h55, "cnt_en_off");
        drive(1'b1, 8'hE3, 8'hAA, 8'h56, "reserved_ignored");
        drive(1'b1, 8'h01, 8'hAA, 8'h55, "dir_change");

        // Asynchronous reset between edges while counting.
        drive(1'b1, 8'h04, 8'h3F, 8'h3F, "load_3f");
        drive(1'b1, 8'h03, 8'h00, 8'h40, "cnt_40");
        rst_n = 1'b0;
        #2;
        check("async_reset_mid", {8'h00, uo_out}, 16'h0000);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 8'h03, 8'h00, 8'h01, "resume_01");
        drive(1'b1, 8'h03, 8'h00, 8'h02, "resume_02");

        @(posedge clk);
        #2;
        check("scoreboard_drained", 16'(sb.size()), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tt_um_up_down_counter.md
Name: tt_um_up_down_counter

Overview:
- 8-bit synchronous up/down counter wrapped in the standard TinyTapeout user-project interface.
- Supports count enable, direction select, synchronous clear, parallel load and wrap/saturate mode.
- Count value drives uo_out directly.
- All uio pins are inputs carrying the parallel-load value.

Parameters:
- WIDTH, 8, counter width; fixed at 8 by the pin map, not overridden at top level.
- RESET_VAL, 8'h00, counter value after reset.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  reset; one clock, asynchronous assert, active-low, reset is asynchronous and active-low.
- ena  input  1  design-selected; when 0, counter holds (clear/load also ignored).
- ui_in  input  8  controls: [0] cnt_en, [1] up (1=up, 0=down), [2] load, [3] sat (1=saturate, 0=wrap), [4] clr (synchronous clear), [7:5] reserved/ignored.
- uo_out  output  8  current count value.
- uio_in  input  8  parallel load value.
- uio_out  output  8  tied 8'h00.
- uio_oe  output  8  tied 8'h00 (all bidirectionals are inputs).

Behaviour:
- Reset: rst_n=0 sets count to RESET_VAL (8'h00) immediately, independent of clk.
  - uo_out=8'h00 while in reset and after release until the first active edge.
  - uio_out and uio_oe are constant 0 at all times.
- Per rising clk edge, when rst_n=1, apply exactly one action, first match wins:
  1. ena=0: hold.
  2. clr=1: count <= 8'h00.
  3. load=1: count <= uio_in.
  4. cnt_en=1, up=1:
     - wrap mode: count <= count+1 mod 256.
     - sat mode: count stays at 8'hFF once reached.
  5. cnt_en=1, up=0:
     - wrap mode: count <= count-1 mod 256.
     - sat mode: count stays at 8'h00 once reached.
  6. Otherwise: hold.
- Latency:
  - uo_out is the register output directly (no output logic).
  - A change applied at edge N is visible on uo_out after edge N.
  - Inputs sampled at the edge; no input synchronizers.
- Boundaries:
  - Wrap up 8'hFF -> 8'h00; wrap down 8'h00 -> 8'hFF.
  - Saturate holds at 8'hFF (up) or 8'h00 (down).
  - Load with cnt_en=1 loads only; counting resumes next cycle.
  - clr and load together: clr wins.
  - Direction or sat change takes effect at the next edge, no glitch, no extra step.
  - Reset mid-operation overrides everything asynchronously; after release the counter restarts from 8'h00.
- Arithmetic: 8-bit unsigned; carry/borrow discarded in wrap mode.
- Reserved ui_in[7:5] have no effect.
- No combinational path from any input to uo_out.

Decomposition:
- Shared package (updown_counter_pkg):
  - constants WIDTH=8 and RESET_VAL.
  - bit-index localparams for ui_in fields: CNT_EN=0, UP=1, LOAD=2, SAT=3, CLR=4.
- Natural sub-module: updown_counter_core, holding:
  - register.
  - clr/load/count priority.
  - wrap/saturate next-state logic.
- Top level only unpacks ui_in, ties uio_out/uio_oe, and maps count to uo_out.

Test Plan:
- Reset: hold rst_n=0 with ui_in=8'h03 for 5 cycles -> uo_out=8'h00; release, 3 cycles of ui_in=8'h03 (en, up, wrap) -> uo_out=8'h03; uio_oe=uio_out=8'h00 throughout.
- Up-wrap: load 8'hFE (ui_in=8'h04, uio_in=8'hFE), then ui_in=8'h03 for 3 edges -> 8'hFF, 8'h00, 8'h01.
- Down-wrap vs saturate:
  - load 8'h01, ui_in=8'h01 -> 8'h00 then 8'hFF.
  - repeat with ui_in=8'h09 -> 8'h00, 8'h00.
- Saturate up: load 8'hFD, ui_in=8'h0B for 5 edges -> 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF.
- Priority/hold:
  - ui_in=8'h17 with uio_in=8'h55 -> 8'h00 (clr wins).
  - ui_in=8'h07 -> 8'h55.
  - ena=0 with ui_in=8'h03 for 4 edges -> stays 8'h55.
  - ui_in=8'h02 (cnt_en=0) -> holds.
- Async reset mid-count: counting up at 8'h40, drop rst_n between edges -> uo_out=8'h00 before the next clk edge; after release, resumes 8'h01, 8'h02.
